// File: rtl/tt_pin_conditioner.sv
// Pin-conditioning harness between a dev-board top level and a tt04-style core.
// Synchronises and optionally debounces inputs, stretches the core reset,
// generates a selectable clock-enable tick and registers all pin outputs.
module tt_pin_conditioner #(
    parameter int unsigned     N_UI        = 8,
    parameter int unsigned     N_UO        = 8,
    parameter int unsigned     N_UIO       = 8,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter logic [N_UI-1:0] DEB_MASK    = '0,
    parameter int unsigned     DEB_CYCLES  = 16,
    parameter int unsigned     RST_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_UI-1:0]  pin_ui,
    input  logic [N_UIO-1:0] pin_uio_in,
    input  logic             pin_ena,
    input  logic [2:0]       div_sel,
    input  logic [N_UO-1:0]  core_uo_out,
    input  logic [N_UIO-1:0] core_uio_out,
    input  logic [N_UIO-1:0] core_uio_oe,
    output logic [N_UI-1:0]  ui_in,
    output logic [N_UIO-1:0] uio_in,
    output logic             ena,
    output logic             core_rst_n,
    output logic             tick,
    output logic [N_UO-1:0]  pin_uo,
    output logic [N_UIO-1:0] pin_uio_out,
    output logic [N_UIO-1:0] pin_uio_oe
);

    localparam int unsigned DCNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned RCNT_W = 8;
    localparam int unsigned TCNT_W = 7;

    logic [N_UI-1:0]        ui_sync  [SYNC_STAGES];
    logic [N_UIO-1:0]       uio_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ena_sync;
    logic [RCNT_W-1:0]      rcnt;
    logic [TCNT_W-1:0]      tcnt;
    logic [TCNT_W-1:0]      tick_mask_c;

    // Multi-stage synchronisers for all asynchronous pin inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                ui_sync[s]  <= '0;
                uio_sync[s] <= '0;
            end
            ena_sync <= '0;
        end else begin
            ui_sync[0]  <= pin_ui;
            uio_sync[0] <= pin_uio_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                ui_sync[s]  <= ui_sync[s-1];
                uio_sync[s] <= uio_sync[s-1];
            end
            ena_sync <= {ena_sync[SYNC_STAGES-2:0], pin_ena};
        end
    end

    // Per-bit debounce on selected ui bits; other bits pass straight from the synchroniser
    genvar gi;
    generate
        for (gi = 0; gi < int'(N_UI); gi++) begin : g_ui
            if (DEB_MASK[gi]) begin : g_deb
                logic [DCNT_W-1:0] dcnt;
                logic              deb_q;

                // Accept a new level only after it persists for DEB_CYCLES cycles
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        dcnt  <= '0;
                        deb_q <= 1'b0;
                    end else if (ui_sync[SYNC_STAGES-1][gi] == deb_q) begin
                        dcnt <= '0;
                    end else if (dcnt == DCNT_W'(DEB_CYCLES - 1)) begin
                        deb_q <= ui_sync[SYNC_STAGES-1][gi];
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + DCNT_W'(1);
                    end
                end

                assign ui_in[gi] = deb_q;
            end else begin : g_raw
                assign ui_in[gi] = ui_sync[SYNC_STAGES-1][gi];
            end
        end
    endgenerate

    // Driven uio bits loop back the registered output so stale pad values never reach the core
    assign uio_in = (pin_uio_oe & pin_uio_out) | (~pin_uio_oe & uio_sync[SYNC_STAGES-1]);
    assign ena    = ena_sync[SYNC_STAGES-1];

    // Reset stretcher: asynchronous assertion, release one edge after rcnt reaches RST_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt       <= '0;
            core_rst_n <= 1'b0;
        end else if (rcnt == RCNT_W'(RST_CYCLES)) begin
            core_rst_n <= 1'b1;
        end else begin
            rcnt <= rcnt + RCNT_W'(1);
        end
    end

    // Free-running tick counter, parked at zero while the core is in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (!core_rst_n) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TCNT_W'(1);
        end
    end

    // Tick fires when the low div_sel counter bits are all ones; div_sel acts immediately
    assign tick_mask_c = TCNT_W'((8'd1 << div_sel) - 8'd1);
    assign tick        = core_rst_n & ((tcnt & tick_mask_c) == tick_mask_c);

    // Output registers toward the pins, forced low (all uio as inputs) during core reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_uo      <= '0;
            pin_uio_out <= '0;
            pin_uio_oe  <= '0;
        end else if (!core_rst_n) begin
            pin_uo      <= '0;
            pin_uio_out <= '0;
            pin_uio_oe  <= '0;
        end else begin
            pin_uo      <= core_uo_out;
            pin_uio_out <= core_uio_out;
            pin_uio_oe  <= core_uio_oe;
        end
    end

endmodule

// File: tb/tb_tt_pin_conditioner.sv
// Self-checking bench for tt_pin_conditioner: hand sequences for reset, debounce,
// latency and tick corners, a vector table for output registering and loopback,
// and a randomized run against a history-based reference model.
module tb_tt_pin_conditioner;

    localparam int unsigned P_SYNC     = 2;
    localparam logic [7:0]  P_DEB_MASK = 8'h01;
    localparam int unsigned P_DEB      = 16;
    localparam int unsigned P_RST      = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pin_ui, pin_uio_in, core_uo_out, core_uio_out, core_uio_oe;
    logic       pin_ena;
    logic [2:0] div_sel;
    logic [7:0] ui_in, uio_in, pin_uo, pin_uio_out, pin_uio_oe;
    logic       ena, core_rst_n, tick;

    int n_chk  = 0;
    int n_fail = 0;

    tt_pin_conditioner #(
        .N_UI(8), .N_UO(8), .N_UIO(8), .SYNC_STAGES(P_SYNC),
        .DEB_MASK(P_DEB_MASK), .DEB_CYCLES(P_DEB), .RST_CYCLES(P_RST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin_ui(pin_ui), .pin_uio_in(pin_uio_in),
        .pin_ena(pin_ena), .div_sel(div_sel), .core_uo_out(core_uo_out),
        .core_uio_out(core_uio_out), .core_uio_oe(core_uio_oe), .ui_in(ui_in),
        .uio_in(uio_in), .ena(ena), .core_rst_n(core_rst_n), .tick(tick),
        .pin_uo(pin_uo), .pin_uio_out(pin_uio_out), .pin_uio_oe(pin_uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pin histories, run lengths and elapsed-cycle counts
    logic [7:0] m_ui_q[$];
    logic [7:0] m_uio_q[$];
    logic       m_ena_q[$];
    logic [7:0] m_deb, m_uo, m_uout, m_oe, m_s;
    int         m_run[8];
    int         m_rel, m_n;
    logic       m_core_was;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rel = 0; m_n = 0; m_deb = '0; m_uo = '0; m_uout = '0; m_oe = '0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
            m_ui_q.delete(); m_uio_q.delete(); m_ena_q.delete();
            for (int k = 0; k < int'(P_SYNC); k++) begin
                m_ui_q.push_back(8'h00); m_uio_q.push_back(8'h00); m_ena_q.push_back(1'b0);
            end
        end else begin
            m_core_was = (m_rel >= int'(P_RST) + 1);
            m_s = m_ui_q[P_SYNC-1];
            for (int i = 0; i < 8; i++) begin
                if (P_DEB_MASK[i]) begin
                    if (m_s[i] != m_deb[i]) begin
                        m_run[i]++;
                        if (m_run[i] == int'(P_DEB)) begin
                            m_deb[i] = m_s[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_ui_q.push_front(pin_ui);      void'(m_ui_q.pop_back());
            m_uio_q.push_front(pin_uio_in); void'(m_uio_q.pop_back());
            m_ena_q.push_front(pin_ena);    void'(m_ena_q.pop_back());
            if (m_core_was) begin
                m_uo = core_uo_out; m_uout = core_uio_out; m_oe = core_uio_oe;
                m_n++;
            end else begin
                m_uo = '0; m_uout = '0; m_oe = '0;
                m_n = 0;
            end
            if (m_rel < 100000) m_rel++;
        end
    end

    task automatic chk_model();
        logic [7:0] e_ui, e_uin;
        logic [6:0] mask, phase;
        logic       e_core, e_tick;
        e_core = (m_rel >= int'(P_RST) + 1);
        for (int i = 0; i < 8; i++) e_ui[i] = P_DEB_MASK[i] ? m_deb[i] : m_ui_q[P_SYNC-1][i];
        e_uin  = (m_oe & m_uout) | (~m_oe & m_uio_q[P_SYNC-1]);
        mask   = 7'((1 << div_sel) - 1);
        phase  = 7'(m_n % 128);
        e_tick = e_core && ((phase & mask) == mask);
        chk("rnd ui_in",       32'(ui_in),       32'(e_ui));
        chk("rnd uio_in",      32'(uio_in),      32'(e_uin));
        chk("rnd ena",         32'(ena),         32'(m_ena_q[P_SYNC-1]));
        chk("rnd core_rst_n",  32'(core_rst_n),  32'(e_core));
        chk("rnd tick",        32'(tick),        32'(e_tick));
        chk("rnd pin_uo",      32'(pin_uo),      32'(m_uo));
        chk("rnd pin_uio_out", 32'(pin_uio_out), 32'(m_uout));
        chk("rnd pin_uio_oe",  32'(pin_uio_oe),  32'(m_oe));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ui_in"},       32'(ui_in),       32'h0);
        chk({tag, " uio_in"},      32'(uio_in),      32'h0);
        chk({tag, " ena"},         32'(ena),         32'h0);
        chk({tag, " core_rst_n"},  32'(core_rst_n),  32'h0);
        chk({tag, " tick"},        32'(tick),        32'h0);
        chk({tag, " pin_uo"},      32'(pin_uo),      32'h0);
        chk({tag, " pin_uio_out"}, 32'(pin_uio_out), 32'h0);
        chk({tag, " pin_uio_oe"},  32'(pin_uio_oe),  32'h0);
    endtask

    typedef struct {
        logic [7:0] uo, uout, oe, pin;
        logic [7:0] e_uo, e_uout, e_oe, e_uin;
    } vec_t;

    vec_t vecs[5];
    logic found;

    initial begin
        vecs[0] = '{8'h5A, 8'hA5, 8'hF0, 8'h3C, 8'h5A, 8'hA5, 8'hF0, 8'hAC};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'h81, 8'h00, 8'hFF, 8'h00, 8'h81};
        vecs[2] = '{8'hFF, 8'h0F, 8'hFF, 8'hF0, 8'hFF, 8'h0F, 8'hFF, 8'h0F};
        vecs[3] = '{8'h3C, 8'h12, 8'h0F, 8'h5A, 8'h3C, 8'h12, 8'h0F, 8'h52};
        vecs[4] = '{8'hA5, 8'hC3, 8'h3C, 8'h99, 8'hA5, 8'hC3, 8'h3C, 8'h81};

        rst_n = 1'b0; pin_ui = '0; pin_uio_in = '0; pin_ena = 1'b0; div_sel = 3'd0;
        core_uo_out = '0; core_uio_out = '0; core_uio_oe = '0;
        #2;
        chk_all_zero("reset");

        // Reset release: core_rst_n on edge 9, outputs forced low until then
        @(negedge clk); @(negedge clk);
        core_uio_oe = 8'hFF; core_uo_out = 8'hFF;
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            chk("release core_rst_n", 32'(core_rst_n), 32'(e >= 9));
            chk("release pin_uio_oe", 32'(pin_uio_oe), (e >= 10) ? 32'hFF : 32'h00);
        end
        chk("release tick ds0", 32'(tick), 32'h1);

        // Output registering and uio loopback vectors
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            pin_uio_in = vecs[v].pin;
            repeat (3) @(negedge clk);
            core_uo_out = vecs[v].uo; core_uio_out = vecs[v].uout; core_uio_oe = vecs[v].oe;
            @(negedge clk);
            chk("vec pin_uo",      32'(pin_uo),      32'(vecs[v].e_uo));
            chk("vec pin_uio_out", 32'(pin_uio_out), 32'(vecs[v].e_uout));
            chk("vec pin_uio_oe",  32'(pin_uio_oe),  32'(vecs[v].e_oe));
            chk("vec uio_in",      32'(uio_in),      32'(vecs[v].e_uin));
        end

        // Unmasked input: two-cycle latency
        @(negedge clk); pin_ui = 8'h80;
        @(negedge clk); chk("ui7 after 1", 32'(ui_in[7]), 32'h0);
        @(negedge clk); chk("ui7 after 2", 32'(ui_in[7]), 32'h1);

        // Debounce: a 15-cycle pulse is rejected
        @(negedge clk); pin_ui[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk); chk("deb pulse", 32'(ui_in[0]), 32'h0);
        end
        pin_ui[0] = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk); chk("deb after pulse", 32'(ui_in[0]), 32'h0);
        end
        // Debounce: a held level appears 18 cycles after the pin change
        pin_ui[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); chk("deb level", 32'(ui_in[0]), 32'(k >= 18));
        end

        // Tick divider: period 8, constant, period 128
        div_sel = 3'd3;
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            @(negedge clk); if (tick) found = 1'b1;
        end
        chk("tick ds3 seen", 32'(found), 32'h1);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk); chk("tick ds3 period", 32'(tick), 32'((i % 8) == 0));
        end
        div_sel = 3'd0;
        for (int i = 0; i < 10; i++) begin
            #1; chk("tick ds0 const", 32'(tick), 32'h1);
            @(negedge clk);
        end
        div_sel = 3'd7;
        found = 1'b0;
        for (int k = 0; k < 140 && !found; k++) begin
            @(negedge clk); if (tick) found = 1'b1;
        end
        chk("tick ds7 seen", 32'(found), 32'h1);
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk); chk("tick ds7 period", 32'(tick), 32'((i % 128) == 0));
        end

        // Asynchronous reset mid-run with everything driven high
        @(negedge clk);
        core_uo_out = 8'hFF; core_uio_out = 8'hFF; core_uio_oe = 8'hFF;
        pin_ui = 8'hFF; pin_uio_in = 8'hFF; pin_ena = 1'b1; div_sel = 3'd0;
        repeat (20) @(negedge clk);
        chk("pre-reset pin_uo", 32'(pin_uo), 32'hFF);
        chk("pre-reset ena",    32'(ena),    32'h1);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async reset");
        @(negedge clk); rst_n = 1'b1;

        // Randomized run against the reference model
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            chk_model();
            pin_ui[7:1]  = 7'($urandom);
            if ($urandom_range(0, 11) == 0) pin_ui[0] = ~pin_ui[0];
            pin_uio_in   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pin_ena = ~pin_ena;
            core_uo_out  = 8'($urandom);
            core_uio_out = 8'($urandom);
            core_uio_oe  = 8'($urandom);
            if ($urandom_range(0, 39) == 0) div_sel = 3'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_pin_conditioner.md
# tt_pin_conditioner

Parametrised pin-conditioning harness that sits between a dev-board top level and a `tt04_design`-style core. It synchronises and optionally debounces the dedicated and bidirectional input pins, and stretches reset with synchronous release. It generates a run-time selectable clock-enable tick for slowing the core relative to the on-board oscillator, and registers all outputs and output-enables toward the pins. All logic is in one clock domain.

## Interface

Parameters:
- `N_UI`, 8, width of dedicated input bus.
- `N_UO`, 8, width of dedicated output bus.
- `N_UIO`, 8, width of bidirectional bus.
- `SYNC_STAGES`, 2, synchroniser depth; legal range 2..4.
- `DEB_MASK`, 8'h00, per-bit enable of debounce on `ui` bits; bit i=1 debounces `pin_ui[i]`.
- `DEB_CYCLES`, 16, number of consecutive clk cycles a changed level must persist; legal range 2..65535.
- `RST_CYCLES`, 8, number of clk cycles `core_rst_n` is held low after `rst_n` release; legal range 1..255.

Ports:
- `clk`  in  1  board oscillator clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pin_ui`  in  N_UI  raw dedicated input pins.
- `pin_uio_in`  in  N_UIO  raw bidirectional pin input values.
- `pin_ena`  in  1  raw enable pin.
- `div_sel`  in  3  tick divider select; tick period is 2^div_sel cycles.
- `core_uo_out`  in  N_UO  core dedicated outputs.
- `core_uio_out`  in  N_UIO  core bidirectional output values.
- `core_uio_oe`  in  N_UIO  core output enables; 1 = output.
- `ui_in`  out  N_UI  conditioned inputs to core.
- `uio_in`  out  N_UIO  conditioned bidirectional inputs to core.
- `ena`  out  1  synchronised enable to core.
- `core_rst_n`  out  1  stretched core reset, active low.
- `tick`  out  1  single-cycle clock-enable pulse.
- `pin_uo`  out  N_UO  registered dedicated outputs.
- `pin_uio_out`  out  N_UIO  registered bidirectional output values.
- `pin_uio_oe`  out  N_UIO  registered output enables.

## Operation

- **Synchronisers:** `pin_ui`, `pin_uio_in` and `pin_ena` each pass through a `SYNC_STAGES`-deep flop chain. All stages reset to 0.
- **Debounce (bits with `DEB_MASK`[i]=1):**
  - Each bit has a counter `dcnt` of width clog2(`DEB_CYCLES`).
  - If the synchronised bit equals `ui_in[i]`, `dcnt` clears to 0.
  - Otherwise `dcnt` increments. When `dcnt == DEB_CYCLES-1` and the bit still differs, `ui_in[i]` takes the new level on that edge and `dcnt` clears.
  - A glitch shorter than `DEB_CYCLES` cycles never reaches `ui_in`.
- **Unmasked `ui` bits:** `ui_in[i]` is the last synchroniser stage, with no extra register.
- **`uio_in` loopback:** for bits with `pin_uio_oe[i]`=1, `uio_in[i]` = `pin_uio_out[i]`. Otherwise it is the last synchroniser stage. Driven pins therefore never feed back stale pad values.
- **`ena`:** the last synchroniser stage of `pin_ena`.
- **Reset stretcher:**
  - An 8-bit counter `rcnt` resets asynchronously to 0, and `core_rst_n` resets asynchronously to 0.
  - After `rst_n` rises, `rcnt` increments each cycle. `core_rst_n` goes high on the edge where `rcnt` reaches `RST_CYCLES`; `rcnt` then saturates.
  - `core_rst_n` assertion is asynchronous; its release is synchronous.
- **Tick generator:**
  - A free-running 7-bit counter `tcnt` resets to 0 and is held at 0 while `core_rst_n`=0.
  - `tick` = 1 when (`tcnt` & mask) == mask, where mask = 2^div_sel − 1. For `div_sel`=0, `tick` is constantly 1 once `core_rst_n`=1.
  - `tick` = 0 while `core_rst_n`=0.
  - A change of `div_sel` takes effect immediately with no counter reset. One shortened or lengthened period is permitted.
- **Output registers:** `pin_uo`, `pin_uio_out` and `pin_uio_oe` sample the core signals every cycle.
  - While `core_rst_n`=0 they are forced to 0, so all uio pins are inputs.

## Timing

- Reset values: `ui_in`, `uio_in`, `ena`, `core_rst_n`, `tick`, `pin_uo`, `pin_uio_out` and `pin_uio_oe` are all 0.
- Latency from pin to core:
  - Unmasked `ui` bits, `uio` inputs and `ena`: `SYNC_STAGES` cycles.
  - Debounced `ui` bits: `SYNC_STAGES` + `DEB_CYCLES` cycles.
- Latency from core to pin: 1 cycle. `uio` loopback adds 0 cycles beyond the output register.
- `core_rst_n` rises exactly `RST_CYCLES` + 1 rising edges after the first edge with `rst_n`=1.
- First `tick` after release: `tcnt` reaches the mask, i.e. 2^div_sel − 1 cycles after `core_rst_n` rises. For `div_sel`=0 the first `tick` coincides with the first cycle of `core_rst_n`=1.
- `rst_n` asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock. `dcnt`, `rcnt` and `tcnt` clear.
- Debounced bit toggling at exactly `DEB_CYCLES` period: no update occurs, because the counter clears on every return to the old level.

## Test plan

- **Reset release:** `RST_CYCLES`=8; release `rst_n` → `core_rst_n` rises on edge 9; all `pin_uio_oe` are 0 before that edge.
- **Reset assertion:** assert `rst_n` between clock edges mid-run → all outputs are 0 with no clock edge.
- **Debounce:** `DEB_MASK`=8'h01, `DEB_CYCLES`=16.
  - 15-cycle pulse on `pin_ui[0]` → `ui_in[0]` stays 0.
  - 16-cycle level → `ui_in[0]` rises 18 cycles after the pin change.
- **Unmasked input:** a step on `pin_ui[7]` appears at `ui_in[7]` after exactly 2 cycles.
- **Tick divider:** `div_sel`=3 → `tick` pulses every 8 cycles. Switch to `div_sel`=0 → `tick` is constantly 1. `div_sel`=7 → period is 128 cycles.
- **uio loopback and registering:**
  - `core_uio_oe`=8'hF0, `core_uio_out`=8'hA5, `pin_uio_in`=8'h3C (stable) → after 1 cycle `pin_uio_oe`=8'hF0 and `uio_in`=8'hAC.
  - `core_uo_out`=8'h5A → `pin_uo`=8'h5A one cycle later.
